// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the five-stage pipeline control unit:
// exception bit positions, mcause codes, stall vectors and FSM states.
package pipe_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STALL_W = 6;

    localparam int unsigned EXC_FETCH_MISALIGN = 0;
    localparam int unsigned EXC_ILLEGAL        = 1;
    localparam int unsigned EXC_EBREAK         = 2;
    localparam int unsigned EXC_LOAD_MISALIGN  = 3;
    localparam int unsigned EXC_STORE_MISALIGN = 4;
    localparam int unsigned EXC_ECALL          = 5;
    localparam int unsigned EXC_MRET           = 6;
    localparam int unsigned EXC_IRQ_EXT        = 7;
    localparam int unsigned EXC_IRQ_TIMER      = 8;

    localparam logic [XLEN-1:0] MCAUSE_IRQ_EXT        = 32'h8000_000B;
    localparam logic [XLEN-1:0] MCAUSE_IRQ_TIMER      = 32'h8000_0007;
    localparam logic [XLEN-1:0] MCAUSE_FETCH_MISALIGN = 32'd0;
    localparam logic [XLEN-1:0] MCAUSE_ILLEGAL        = 32'd2;
    localparam logic [XLEN-1:0] MCAUSE_EBREAK         = 32'd3;
    localparam logic [XLEN-1:0] MCAUSE_LOAD_MISALIGN  = 32'd4;
    localparam logic [XLEN-1:0] MCAUSE_STORE_MISALIGN = 32'd6;
    localparam logic [XLEN-1:0] MCAUSE_ECALL          = 32'd11;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/trap_encode.sv
// Combinational trap decoder: prioritises MEM-stage exception flags into an
// mcause value and computes the redirect target (trap vector or mepc for mret).
module trap_encode
    import pipe_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] exception,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] exception_pc,
    output logic            valid,
    output logic            is_trap,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] trap_pc
);

    logic            irq;
    logic [XLEN-1:0] base;
    logic            unused_exc_hi;

    assign unused_exc_hi = ^exception[XLEN-1:EXC_IRQ_TIMER+1];
    assign trap_pc       = exception_pc;

    always_comb begin
        valid   = |exception[EXC_IRQ_TIMER:0];
        irq     = exception[EXC_IRQ_EXT] | exception[EXC_IRQ_TIMER];
        is_trap = irq | (|exception[EXC_ECALL:0]);
        base    = {mtvec[XLEN-1:2], 2'b00};
        cause   = '0;

        if (exception[EXC_IRQ_EXT])             cause = MCAUSE_IRQ_EXT;
        else if (exception[EXC_IRQ_TIMER])      cause = MCAUSE_IRQ_TIMER;
        else if (exception[EXC_FETCH_MISALIGN]) cause = MCAUSE_FETCH_MISALIGN;
        else if (exception[EXC_ILLEGAL])        cause = MCAUSE_ILLEGAL;
        else if (exception[EXC_EBREAK])         cause = MCAUSE_EBREAK;
        else if (exception[EXC_LOAD_MISALIGN])  cause = MCAUSE_LOAD_MISALIGN;
        else if (exception[EXC_STORE_MISALIGN]) cause = MCAUSE_STORE_MISALIGN;
        else if (exception[EXC_ECALL])          cause = MCAUSE_ECALL;

        // 4*cause[30:0] modulo 2^32 only keeps cause[29:0]
        if (!is_trap)
            target = mepc;
        else if (irq && (mtvec[1:0] == 2'b01))
            target = base + {cause[XLEN-3:0], 2'b00};
        else
            target = base;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stall requests, sequences one-cycle flushes for
// redirects and traps, drives the CSR trap write, and runs a stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stallreq_if_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               stallreq_mem_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    input  logic [XLEN-1:0]    exception_i,
    input  logic [XLEN-1:0]    exception_pc_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               new_pc_valid_o,
    output logic [XLEN-1:0]    new_pc_o,
    output logic               trap_we_o,
    output logic [XLEN-1:0]    trap_mepc_o,
    output logic [XLEN-1:0]    trap_mcause_o,
    output logic               stall_timeout_o
);

    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STALL_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            flush_d, we_d;
    logic [XLEN-1:0] new_pc_d, mepc_d, mcause_d;
    logic [CNT_W-1:0] cnt_q;

    logic            enc_valid, enc_is_trap;
    logic [XLEN-1:0] enc_cause, enc_target, enc_pc;

    trap_encode u_trap_encode (
        .exception    (exception_i),
        .mtvec        (mtvec_i),
        .mepc         (mepc_i),
        .exception_pc (exception_pc_i),
        .valid        (enc_valid),
        .is_trap      (enc_is_trap),
        .cause        (enc_cause),
        .target       (enc_target),
        .trap_pc      (enc_pc)
    );

    // Zero-latency stall merge; the highest requesting stage wins
    always_comb begin
        stall_o = STALL_NONE;
        if (!rst_i && (state_q == ST_RUN)) begin
            if (stallreq_mem_i)     stall_o = STALL_MEM;
            else if (stallreq_ex_i) stall_o = STALL_EX;
            else if (stallreq_id_i) stall_o = STALL_ID;
            else if (stallreq_if_i) stall_o = STALL_IF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            flush_o        <= 1'b0;
            new_pc_valid_o <= 1'b0;
            trap_we_o      <= 1'b0;
            new_pc_o       <= '0;
            trap_mepc_o    <= '0;
            trap_mcause_o  <= '0;
        end else begin
            state_q        <= state_d;
            flush_o        <= flush_d;
            new_pc_valid_o <= flush_d;
            trap_we_o      <= we_d;
            new_pc_o       <= new_pc_d;
            trap_mepc_o    <= mepc_d;
            trap_mcause_o  <= mcause_d;
        end
    end

    // A held MEM stage defers traps, but a redirect may still be taken
    always_comb begin
        state_d  = ST_RUN;
        flush_d  = 1'b0;
        we_d     = 1'b0;
        new_pc_d = new_pc_o;
        mepc_d   = trap_mepc_o;
        mcause_d = trap_mcause_o;
        case (state_q)
            ST_RUN: begin
                if (enc_valid && !stallreq_mem_i) begin
                    state_d  = ST_FLUSH;
                    flush_d  = 1'b1;
                    we_d     = enc_is_trap;
                    new_pc_d = enc_target;
                    if (enc_is_trap) begin
                        mepc_d   = enc_pc;
                        mcause_d = enc_cause;
                    end
                end else if (redirect_i) begin
                    state_d  = ST_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = redirect_pc_i;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Watchdog: counts consecutive stalled cycles, saturates, sticky trip flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q           <= '0;
            stall_timeout_o <= 1'b0;
        end else if (stall_o != STALL_NONE) begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_TRIP) stall_timeout_o <= 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

endmodule
